// File: rtl/frame_stream_sink.sv
// Pixel-stream sink: checks SOF/EOF framing against FRAME_LENGTH and keeps saturating good/error frame counters.
// Latency: frame_done/frame_err/data_err pulses and counter updates appear one cycle after the accepting edge.
// Backpressure: s_ready is enable delayed by one cycle; deasserting it freezes frame tracking. Optional build macro DATA_CHECK_EN adds a sequential-data checker.
module frame_stream_sink #(
    parameter int DATA_WIDTH   = 32,
    parameter int FRAME_LENGTH = 16,
    parameter int CNT_WIDTH    = 16,
    localparam int IDX_W       = $clog2(FRAME_LENGTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    input  logic                  s_last,
    input  logic                  s_user,
    output logic                  s_ready,
    input  logic                  enable,
    input  logic                  clear_stats,
    output logic                  frame_done,
    output logic                  frame_err,
    output logic [CNT_WIDTH-1:0]  frame_count,
    output logic [CNT_WIDTH-1:0]  err_count,
    output logic [IDX_W-1:0]      beat_idx,
    output logic                  data_err,
    output logic [CNT_WIDTH-1:0]  data_err_count
);

    typedef enum logic {SEEK, FRAME} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LENGTH - 1);

    state_t               state_q;
    logic [IDX_W-1:0]     beat_idx_q;
    logic                 s_ready_q;
    logic                 frame_done_q;
    logic                 frame_err_q;
    logic [CNT_WIDTH-1:0] frame_count_q, frame_count_d;
    logic [CNT_WIDTH-1:0] err_count_q, err_count_d;

    logic accept;
    logic at_last_idx;
    logic good_ev;
    logic err_ev;

    assign accept      = s_valid & s_ready_q;
    assign at_last_idx = (beat_idx_q == LAST_IDX);

    // A well-formed frame ends only on a non-SOF EOF beat landing exactly on the final index.
    assign good_ev = accept & (state_q == FRAME) & ~s_user & s_last & at_last_idx;
    // Errors: SOF+EOF together, SOF inside a frame, or EOF placement disagreeing with the index.
    assign err_ev  = accept & ((s_user & (s_last | (state_q == FRAME))) |
                               ((state_q == FRAME) & ~s_user & (s_last ^ at_last_idx)));

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c,
                                                     input logic inc);
        return (inc && (c != '1)) ? c + 1'b1 : c;
    endfunction

    // Frame-position FSM with registered ready and event pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= SEEK;
            beat_idx_q   <= '0;
            s_ready_q    <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            s_ready_q    <= enable;
            frame_done_q <= good_ev;
            frame_err_q  <= err_ev;
            if (accept) begin
                case (state_q)
                    SEEK: begin
                        // Non-SOF beats are dropped; SOF+EOF is a short frame and stays here.
                        if (s_user && !s_last) begin
                            beat_idx_q <= IDX_W'(1);
                            state_q    <= FRAME;
                        end
                    end
                    FRAME: begin
                        if (s_user && s_last) begin
                            beat_idx_q <= '0;
                            state_q    <= SEEK;
                        end else if (s_user) begin
                            // Early SOF restarts the frame from this beat.
                            beat_idx_q <= IDX_W'(1);
                        end else if (s_last || at_last_idx) begin
                            // Good end, short frame or missing EOF: all resynchronise in SEEK.
                            beat_idx_q <= '0;
                            state_q    <= SEEK;
                        end else begin
                            beat_idx_q <= beat_idx_q + 1'b1;
                        end
                    end
                    default: begin
                        beat_idx_q <= '0;
                        state_q    <= SEEK;
                    end
                endcase
            end
        end
    end

    // Next counter values: clear takes priority over any same-cycle increment.
    always_comb begin
        frame_count_d = clear_stats ? '0 : sat_inc(frame_count_q, good_ev);
        err_count_d   = clear_stats ? '0 : sat_inc(err_count_q, err_ev);
    end

    // Statistics counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_count_q <= '0;
            err_count_q   <= '0;
        end else begin
            frame_count_q <= frame_count_d;
            err_count_q   <= err_count_d;
        end
    end

`ifdef DATA_CHECK_EN
    logic [DATA_WIDTH-1:0] ref_q;
    logic [DATA_WIDTH-1:0] ref_inc;
    logic                  data_err_q;
    logic [CNT_WIDTH-1:0]  data_err_count_q, data_err_count_d;
    logic                  data_ev;

    assign ref_inc = ref_q + 1'b1;
    // Only non-SOF beats inside a frame are checked; SOF beats merely seed the reference.
    assign data_ev = accept & (state_q == FRAME) & ~s_user & (s_data != ref_inc);

    // Next data-error count, cleared with the other statistics.
    always_comb begin
        data_err_count_d = clear_stats ? '0 : sat_inc(data_err_count_q, data_ev);
    end

    // Reference tracks the last in-frame value, so a mismatch resynchronises to the received data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_q            <= '0;
            data_err_q       <= 1'b0;
            data_err_count_q <= '0;
        end else begin
            data_err_q       <= data_ev;
            data_err_count_q <= data_err_count_d;
            if (accept && (s_user || (state_q == FRAME))) begin
                ref_q <= s_data;
            end
        end
    end

    assign data_err       = data_err_q;
    assign data_err_count = data_err_count_q;
`else
    logic unused_data;
    assign unused_data    = ^s_data;
    assign data_err       = 1'b0;
    assign data_err_count = '0;
`endif

    assign s_ready     = s_ready_q;
    assign frame_done  = frame_done_q;
    assign frame_err   = frame_err_q;
    assign frame_count = frame_count_q;
    assign err_count   = err_count_q;
    assign beat_idx    = beat_idx_q;

endmodule

// File: tb/tb_frame_stream_sink.sv
// Bench for frame_stream_sink: scenario tasks drive beats, queue expected pulses per accepted beat and compare.
// Pulses sampled 1 time unit after each accepting edge; counters checked at the end of each scenario.
// All waits on s_ready are bounded; a global watchdog ends the run if anything stalls.
module tb_frame_stream_sink;

    localparam int DW = 32;
    localparam int FL = 16;
    localparam int CW = 16;
    localparam int IW = $clog2(FL);
`ifdef DATA_CHECK_EN
    localparam logic DC = 1'b1;
`else
    localparam logic DC = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_last = 1'b0;
    logic          s_user = 1'b0;
    logic          s_ready;
    logic          enable = 1'b0;
    logic          clear_stats = 1'b0;
    logic          frame_done;
    logic          frame_err;
    logic [CW-1:0] frame_count;
    logic [CW-1:0] err_count;
    logic [IW-1:0] beat_idx;
    logic          data_err;
    logic [CW-1:0] data_err_count;

    // {frame_done, frame_err, data_err} per accepted beat
    logic [2:0] exp_q[$];
    logic [2:0] obs_q[$];

    int checks = 0;
    int errors = 0;

    frame_stream_sink #(.DATA_WIDTH(DW), .FRAME_LENGTH(FL), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_user(s_user),
        .s_ready(s_ready), .enable(enable), .clear_stats(clear_stats),
        .frame_done(frame_done), .frame_err(frame_err),
        .frame_count(frame_count), .err_count(err_count), .beat_idx(beat_idx),
        .data_err(data_err), .data_err_count(data_err_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Drive one beat, wait (bounded) for acceptance, record expected and observed pulses.
    task automatic send_beat(input logic [DW-1:0] d, input logic u, input logic l, input logic [2:0] e);
        int n;
        s_data  = d;
        s_user  = u;
        s_last  = l;
        s_valid = 1'b1;
        n = 0;
        while (s_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (s_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: s_ready=%b required 1", s_ready);
        end else begin
            exp_q.push_back(e);
            @(posedge clk); #1;
            obs_q.push_back({frame_done, frame_err, data_err});
        end
    endtask

    // Sixteen sequential beats from base, SOF first, EOF last, frame_done on the final beat.
    task automatic send_frame(input logic [DW-1:0] base);
        for (int i = 0; i < FL; i++) begin
            send_beat(base + DW'(i), (i == 0), (i == FL - 1), {(i == FL - 1), 2'b00});
        end
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        s_user  = 1'b0;
        s_last  = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_clear();
        s_valid     = 1'b0;
        clear_stats = 1'b1;
        @(posedge clk); #1;
        clear_stats = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({s_ready, frame_done, frame_err, data_err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: {rdy,done,err,derr}=%b required 0000",
                     {s_ready, frame_done, frame_err, data_err});
        end
        checks++;
        if ({frame_count, err_count, data_err_count} !== '0 || beat_idx !== '0) begin
            errors++;
            $display("FAIL reset_counters: fc=%0d ec=%0d dc=%0d idx=%0d required all 0",
                     frame_count, err_count, data_err_count, beat_idx);
        end
        enable = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_follows_enable: s_ready=%b required 1", s_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] e, o;
        int k = 0;
        do_clear();
        send_frame(32'd0);
        send_frame(32'd0);
        send_frame(32'd0);
        idle(1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL b2b_pulses beat %0d: {done,err,derr}=%b required %b", k, o, e);
            end
            k++;
        end
        checks++;
        if (frame_count !== 16'd3 || err_count !== 16'd0 || data_err_count !== 16'd0) begin
            errors++;
            $display("FAIL b2b_counts: fc=%0d ec=%0d dc=%0d required 3 0 0", frame_count, err_count, data_err_count);
        end
    endtask

    task automatic test_short_frame();
        logic [2:0] e, o;
        int k = 0;
        do_clear();
        for (int i = 0; i <= 10; i++) begin
            send_beat(DW'(i), (i == 0), (i == 10), {1'b0, (i == 10), 1'b0});
        end
        checks++;
        if (beat_idx !== '0) begin
            errors++;
            $display("FAIL short_idx: beat_idx=%0d required 0", beat_idx);
        end
        send_frame(32'd50);
        idle(1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL short_pulses beat %0d: {done,err,derr}=%b required %b", k, o, e);
            end
            k++;
        end
        checks++;
        if (frame_count !== 16'd1 || err_count !== 16'd1) begin
            errors++;
            $display("FAIL short_counts: fc=%0d ec=%0d required 1 1", frame_count, err_count);
        end
    endtask

    task automatic test_early_sof();
        logic [2:0] e, o;
        int k = 0;
        do_clear();
        for (int i = 0; i < 5; i++) begin
            send_beat(DW'(i), (i == 0), 1'b0, 3'b000);
        end
        send_beat(32'd100, 1'b1, 1'b0, 3'b010);
        checks++;
        if (beat_idx !== IW'(1)) begin
            errors++;
            $display("FAIL early_sof_idx: beat_idx=%0d required 1", beat_idx);
        end
        for (int i = 1; i <= 15; i++) begin
            send_beat(32'd100 + DW'(i), 1'b0, (i == 15), {(i == 15), 2'b00});
        end
        idle(1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL early_sof_pulses beat %0d: {done,err,derr}=%b required %b", k, o, e);
            end
            k++;
        end
        checks++;
        if (frame_count !== 16'd1 || err_count !== 16'd1) begin
            errors++;
            $display("FAIL early_sof_counts: fc=%0d ec=%0d required 1 1", frame_count, err_count);
        end
    endtask

    task automatic test_missing_last();
        logic [2:0] e, o;
        int k = 0;
        do_clear();
        for (int i = 0; i < FL; i++) begin
            send_beat(DW'(i), (i == 0), 1'b0, {1'b0, (i == FL - 1), 1'b0});
        end
        for (int i = 0; i < 4; i++) begin
            send_beat(32'hDEAD_0000 + DW'(i), 1'b0, (i == 3), 3'b000);
        end
        checks++;
        if (beat_idx !== '0) begin
            errors++;
            $display("FAIL missing_last_idx: beat_idx=%0d required 0", beat_idx);
        end
        send_frame(32'd200);
        idle(1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL missing_last_pulses beat %0d: {done,err,derr}=%b required %b", k, o, e);
            end
            k++;
        end
        checks++;
        if (frame_count !== 16'd1 || err_count !== 16'd1) begin
            errors++;
            $display("FAIL missing_last_counts: fc=%0d ec=%0d required 1 1", frame_count, err_count);
        end
    endtask

    // Data values 0..6,8..16: only the beat carrying 8 mismatches (when the checker is built).
    task automatic test_data_check();
        logic [2:0] e, o;
        int k = 0;
        do_clear();
        for (int i = 0; i < FL; i++) begin
            send_beat((i < 7) ? DW'(i) : DW'(i + 1), (i == 0), (i == FL - 1),
                      {(i == FL - 1), 1'b0, DC & (i == 7)});
        end
        send_frame(32'hFFFF_FFF8);
        idle(1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL data_check_pulses beat %0d: {done,err,derr}=%b required %b", k, o, e);
            end
            k++;
        end
        checks++;
        if (data_err_count !== CW'(DC) || frame_count !== 16'd2 || err_count !== 16'd0) begin
            errors++;
            $display("FAIL data_check_counts: dc=%0d fc=%0d ec=%0d required %0d 2 0",
                     data_err_count, frame_count, err_count, DC);
        end
    endtask

    task automatic test_enable_freeze();
        logic [2:0] e, o;
        int k = 0;
        do_clear();
        for (int i = 0; i < 5; i++) begin
            send_beat(DW'(i), (i == 0), 1'b0, 3'b000);
        end
        // Ready is still high this cycle, so beat 5 is taken as enable drops.
        enable = 1'b0;
        send_beat(32'd5, 1'b0, 1'b0, 3'b000);
        s_data = 32'd6;
        repeat (5) begin
            checks++;
            if (s_ready !== 1'b0 || beat_idx !== IW'(6) || frame_err !== 1'b0) begin
                errors++;
                $display("FAIL freeze: rdy=%b idx=%0d err=%b required 0 6 0", s_ready, beat_idx, frame_err);
            end
            @(posedge clk); #1;
        end
        enable = 1'b1;
        for (int i = 6; i < FL; i++) begin
            send_beat(DW'(i), 1'b0, (i == FL - 1), {(i == FL - 1), 2'b00});
        end
        idle(1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL freeze_pulses beat %0d: {done,err,derr}=%b required %b", k, o, e);
            end
            k++;
        end
        checks++;
        if (frame_count !== 16'd1 || err_count !== 16'd0) begin
            errors++;
            $display("FAIL freeze_counts: fc=%0d ec=%0d required 1 0", frame_count, err_count);
        end
    endtask

    task automatic test_reset_and_clear();
        logic [2:0] e, o;
        int k = 0;
        for (int i = 0; i < 4; i++) begin
            send_beat(DW'(i), (i == 0), 1'b0, 3'b000);
        end
        s_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({s_ready, frame_done, frame_err, data_err} !== 4'b0000 ||
            {frame_count, err_count, data_err_count} !== '0 || beat_idx !== '0) begin
            errors++;
            $display("FAIL mid_frame_reset: rdy=%b done=%b err=%b fc=%0d ec=%0d idx=%0d required all 0",
                     s_ready, frame_done, frame_err, frame_count, err_count, beat_idx);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        // An EOF-only beat must be ignored if the FSM really restarted in SEEK.
        send_beat(32'd4, 1'b0, 1'b1, 3'b000);
        idle(1);
        checks++;
        if (err_count !== 16'd0 || beat_idx !== '0) begin
            errors++;
            $display("FAIL after_reset_seek: ec=%0d idx=%0d required 0 0", err_count, beat_idx);
        end
        send_frame(32'd300);
        idle(1);
        checks++;
        if (frame_count !== 16'd1) begin
            errors++;
            $display("FAIL pre_clear_count: fc=%0d required 1", frame_count);
        end
        for (int i = 0; i < FL - 1; i++) begin
            send_beat(32'd400 + DW'(i), (i == 0), 1'b0, 3'b000);
        end
        clear_stats = 1'b1;
        send_beat(32'd415, 1'b0, 1'b1, 3'b100);
        clear_stats = 1'b0;
        checks++;
        if (frame_count !== 16'd0) begin
            errors++;
            $display("FAIL clear_wins: fc=%0d required 0", frame_count);
        end
        idle(1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset_clear_pulses beat %0d: {done,err,derr}=%b required %b", k, o, e);
            end
            k++;
        end
        checks++;
        if (frame_count !== 16'd0 || err_count !== 16'd0) begin
            errors++;
            $display("FAIL post_clear_counts: fc=%0d ec=%0d required 0 0", frame_count, err_count);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_short_frame();
        test_early_sof();
        test_missing_last();
        test_data_check();
        test_enable_freeze();
        test_reset_and_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_stream_sink.md
# frame_stream_sink

Receiving end of the pixel-stream interface driven by the project's stream sources (data/valid/last/user, user = start-of-frame, last = end-of-frame). Accepts beats under a valid/ready handshake and tracks frame position against a fixed frame length. Detects framing violations and, optionally, sequential-data errors. Publishes per-frame pulses and saturating statistics counters for the Wiener-filter input path and its testbenches.

## Interface
- DATA_WIDTH, 32, stream data width
- FRAME_LENGTH, 16, beats per frame; legal range ≥ 2
- CNT_WIDTH, 16, width of statistics counters
- clk  in  1  clock; all logic on posedge
- rst_n  in  1  asynchronous, active-low reset
- s_data  in  DATA_WIDTH  stream data
- s_valid  in  1  beat valid
- s_last  in  1  end-of-frame marker
- s_user  in  1  start-of-frame marker
- s_ready  out  1  sink ready; registered copy of enable
- enable  in  1  allow acceptance
- clear_stats  in  1  synchronous clear of all counters
- frame_done  out  1  one-cycle pulse: well-formed frame completed
- frame_err  out  1  one-cycle pulse: framing violation
- frame_count  out  CNT_WIDTH  good frames, saturating
- err_count  out  CNT_WIDTH  framing errors, saturating
- beat_idx  out  $clog2(FRAME_LENGTH)  index of next expected beat in frame
- data_err  out  1  one-cycle pulse, DATA_CHECK_EN only
- data_err_count  out  CNT_WIDTH  saturating, DATA_CHECK_EN only

## Operation
- Accept = s_valid & s_ready. Only accepted beats affect state. Upstream holds data and markers while valid & !ready.
- FSM states:
  - SEEK: waiting for SOF.
  - FRAME: inside a frame.
- SEEK:
  - Accepted beat with user=0 is discarded silently.
  - Accepted beat with user=1 and last=0: beat_idx←1, go to FRAME.
  - Accepted beat with user=1 and last=1: short-frame error. frame_err pulses, err_count increments, stay in SEEK.
- FRAME, per accepted beat, in priority order:
  1. user=1: early-SOF error. frame_err pulses, err_count increments. The beat restarts the frame: beat_idx←1, stay in FRAME. If last=1 is also set, apply the SEEK rule for user=1 & last=1 instead.
  2. last=1 and beat_idx==FRAME_LENGTH-1: good frame. frame_done pulses, frame_count increments, go to SEEK, beat_idx←0.
  3. last=1 and beat_idx<FRAME_LENGTH-1: short-frame error. Go to SEEK.
  4. last=0 and beat_idx==FRAME_LENGTH-1: missing-last error. Go to SEEK; later beats are discarded until the next user beat.
  5. Otherwise: beat_idx increments.
- Counters saturate at all-ones and never wrap.
- clear_stats zeroes all counters. If a clear and an increment happen in the same cycle, the clear wins. The pulse outputs still fire.
- clear_stats does not affect the FSM.

## Timing
- Reset values: s_ready=0, frame_done=0, frame_err=0, data_err=0, all counters 0, beat_idx=0, FSM=SEEK, reference register 0.
- s_ready follows enable with 1-cycle latency. Deasserting enable mid-frame freezes the FSM; no error is raised.
- frame_done, frame_err, data_err and counter updates are registered. They are visible on the cycle after the accepting edge.
- Pulses last one cycle. Back-to-back frames may produce frame_done on consecutive frames without gap cycles.
- beat_idx updates on the accepting edge.
- Reset mid-frame: immediate return to reset values. The partial frame is not counted as an error.
- Sustained throughput: one beat per cycle.

## Configuration
- DATA_CHECK_EN defined:
  - A DATA_WIDTH reference register stores the last accepted data value in the current frame.
  - Each non-first beat of a frame must equal reference+1 (mod 2^DATA_WIDTH).
  - A mismatch pulses data_err and increments data_err_count. The reference is then reloaded with the received value.
  - A data error does not change FSM behaviour; frame_done still fires if framing is correct.
  - The first beat of a frame (user=1) only loads the reference.
- DATA_CHECK_EN undefined: data_err and data_err_count are tied to 0. No reference register or comparator is built.

## Test plan
- enable=1, three back-to-back frames of 16 sequential beats (user on beat 0, last on beat 15): 3 frame_done pulses, frame_count=3, err_count=0, frame_err never set.
- Frame with last on beat 10, then one good frame: one frame_err one cycle after beat 10, err_count=1, frame_count=1.
- user re-asserted on beat 5, followed by 15 more correctly framed beats: err_count=1; the restarted frame completes and frame_count=1.
- last omitted on beat 15, 4 filler beats, then a good frame: frame_err on beat 15, fillers ignored, frame_count=1, err_count=1.
- DATA_CHECK_EN defined, frame data 0..6,8..16 (value 7 skipped): data_err_count=1, frame_done still pulses. Additionally, data 0xFFFFFFFF→0x0 inside a frame raises no error.
- enable=0 for 5 cycles mid-frame with s_valid held: s_ready low from the next cycle and beat_idx frozen. Then assert rst_n=0 mid-frame: all outputs 0 and FSM back in SEEK. Finally pulse clear_stats together with a frame_done: frame_count reads 0.
